// File: rtl/unity_decode_ctrl.sv
// rtl/unity_decode_ctrl.sv - Unity-ECC dual-path decode transaction controller
// Launches SSC and DEC paths per codeword, collects results with timeout, selects min-result.
module unity_decode_ctrl #(
  parameter int CW_W    = 80,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [CW_W-1:0]   req_cw_in,
  output logic              dec1_start_out,
  output logic              dec2_start_out,
  output logic [CW_W-1:0]   dec_cw_out,
  input  logic              dec1_done_in,
  input  logic              dec1_result_in,
  input  logic [DATA_W-1:0] dec1_data_in,
  input  logic              dec2_done_in,
  input  logic              dec2_result_in,
  input  logic [DATA_W-1:0] dec2_data_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic              rsp_result_out,
  output logic [DATA_W-1:0] rsp_data_out,
  output logic              rsp_path_out,
  output logic              rsp_timeout_out,
  input  logic              clr_cnt_in,
  output logic [CNT_W-1:0]  due_cnt_out,
  output logic [CNT_W-1:0]  disagree_cnt_out,
  output logic [CNT_W-1:0]  timeout_cnt_out
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                cap1_q, cap1_d, cap2_q, cap2_d;
  logic                r1_q, r1_d, r2_q, r2_d;
  logic [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic                res_q, res_d, path_q, path_d, to_q, to_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    due_q, due_d, dis_q, dis_d, tcnt_q, tcnt_d;
  logic                last_wait, force1, force2, rsp_hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  assign last_wait = (wcnt_q == WC_W'(TIMEOUT - 1));
  assign rsp_hs    = (state_q == S_RESP) && rsp_ready_in;

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    wcnt_d  = wcnt_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    res_d   = res_q;
    data_d  = data_q;
    path_d  = path_q;
    to_d    = to_q;
    force1  = 1'b0;
    force2  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          state_d = S_LAUNCH;
          cw_d    = req_cw_in;
          cap1_d  = 1'b0;
          cap2_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // A real done in the final wait cycle takes priority over forcing DUE.
        if (!cap1_q) begin
          if (dec1_done_in) begin
            cap1_d = 1'b1;
            r1_d   = dec1_result_in;
            d1_d   = dec1_data_in;
          end else if (last_wait) begin
            cap1_d = 1'b1;
            r1_d   = 1'b1;
            d1_d   = '0;
            force1 = 1'b1;
          end
        end
        if (!cap2_q) begin
          if (dec2_done_in) begin
            cap2_d = 1'b1;
            r2_d   = dec2_result_in;
            d2_d   = dec2_data_in;
          end else if (last_wait) begin
            cap2_d = 1'b1;
            r2_d   = 1'b1;
            d2_d   = '0;
            force2 = 1'b1;
          end
        end
        // Forcing only ever happens in the cycle that completes the transaction.
        if (cap1_d && cap2_d) begin
          state_d = S_RESP;
          to_d    = force1 | force2;
          if (r1_d < r2_d) begin
            res_d  = r1_d;
            data_d = d1_d;
            path_d = 1'b0;
          end else begin
            res_d  = r2_d;
            data_d = d2_d;
            path_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    due_d  = sat_inc(due_q,  rsp_hs && res_q);
    dis_d  = sat_inc(dis_q,  rsp_hs && (r1_q != r2_q));
    tcnt_d = sat_inc(tcnt_q, rsp_hs && to_q);
    if (clr_cnt_in) begin
      due_d  = '0;
      dis_d  = '0;
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cw_q    <= '0;
      wcnt_q  <= '0;
      cap1_q  <= 1'b0;
      cap2_q  <= 1'b0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      res_q   <= 1'b0;
      data_q  <= '0;
      path_q  <= 1'b0;
      to_q    <= 1'b0;
      due_q   <= '0;
      dis_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      wcnt_q  <= wcnt_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      res_q   <= res_d;
      data_q  <= data_d;
      path_q  <= path_d;
      to_q    <= to_d;
      due_q   <= due_d;
      dis_q   <= dis_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign req_ready_out    = (state_q == S_IDLE);
  assign dec1_start_out   = (state_q == S_LAUNCH);
  assign dec2_start_out   = (state_q == S_LAUNCH);
  assign dec_cw_out       = cw_q;
  assign rsp_valid_out    = (state_q == S_RESP);
  assign rsp_result_out   = res_q;
  assign rsp_data_out     = data_q;
  assign rsp_path_out     = path_q;
  assign rsp_timeout_out  = to_q;
  assign due_cnt_out      = due_q;
  assign disagree_cnt_out = dis_q;
  assign timeout_cnt_out  = tcnt_q;

endmodule

// File: tb/tb_unity_decode_ctrl.sv
// tb/tb_unity_decode_ctrl.sv - directed table-driven bench for unity_decode_ctrl
// Uses TIMEOUT=16 and CNT_W=2 so counter saturation is reachable.
module tb_unity_decode_ctrl;

  localparam int CW_W = 80, DATA_W = 64, TIMEOUT = 16, CNT_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid_in, req_ready_out;
  logic [CW_W-1:0]   req_cw_in, dec_cw_out;
  logic              dec1_start_out, dec2_start_out;
  logic              dec1_done_in, dec1_result_in, dec2_done_in, dec2_result_in;
  logic [DATA_W-1:0] dec1_data_in, dec2_data_in, rsp_data_out;
  logic              rsp_valid_out, rsp_ready_in, rsp_result_out, rsp_path_out, rsp_timeout_out;
  logic              clr_cnt_in;
  logic [CNT_W-1:0]  due_cnt_out, disagree_cnt_out, timeout_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unity_decode_ctrl #(.CW_W(CW_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_cw_in(req_cw_in),
    .dec1_start_out(dec1_start_out), .dec2_start_out(dec2_start_out), .dec_cw_out(dec_cw_out),
    .dec1_done_in(dec1_done_in), .dec1_result_in(dec1_result_in), .dec1_data_in(dec1_data_in),
    .dec2_done_in(dec2_done_in), .dec2_result_in(dec2_result_in), .dec2_data_in(dec2_data_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in), .rsp_result_out(rsp_result_out),
    .rsp_data_out(rsp_data_out), .rsp_path_out(rsp_path_out), .rsp_timeout_out(rsp_timeout_out),
    .clr_cnt_in(clr_cnt_in), .due_cnt_out(due_cnt_out), .disagree_cnt_out(disagree_cnt_out),
    .timeout_cnt_out(timeout_cnt_out)
  );

  typedef struct {
    logic [CW_W-1:0]   cw;
    logic              r1;
    logic [DATA_W-1:0] d1;
    int                k1;
    int                k1b;
    logic              r2;
    logic [DATA_W-1:0] d2;
    int                k2;
    logic              er;
    logic [DATA_W-1:0] ed;
    logic              ep;
    logic              et;
    int                lat;
  } vec_t;

  localparam logic [DATA_W-1:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [DATA_W-1:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [DATA_W-1:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int due, input int dis, input int tmo);
    chk({nm, ".due_cnt"}, 80'(due_cnt_out), 80'(due));
    chk({nm, ".disagree_cnt"}, 80'(disagree_cnt_out), 80'(dis));
    chk({nm, ".timeout_cnt"}, 80'(timeout_cnt_out), 80'(tmo));
  endtask

  task automatic pulse_clr();
    clr_cnt_in = 1'b1;
    step();
    clr_cnt_in = 1'b0;
  endtask

  // Full transaction with rsp_ready_in high; entered and left in IDLE, #1 after an edge.
  task automatic do_txn(input vec_t v, input string nm, input bit clr_hs);
    bit seen = 1'b0;
    int lat  = 0;
    chk({nm, ".req_ready"}, 80'(req_ready_out), 80'(1));
    req_valid_in = 1'b1;
    req_cw_in    = v.cw;
    rsp_ready_in = 1'b1;
    step();
    req_valid_in = 1'b0;
    chk({nm, ".start"}, 80'({dec1_start_out, dec2_start_out}), 80'(2'b11));
    chk({nm, ".dec_cw"}, 80'(dec_cw_out), v.cw);
    for (int j = 0; j < 40 && !seen; j++) begin
      step();
      dec1_done_in = 1'b0;
      dec2_done_in = 1'b0;
      if (rsp_valid_out) begin
        seen = 1'b1;
        lat  = j + 2;
      end else begin
        dec1_done_in   = (j == v.k1) || (j == v.k1b);
        dec1_result_in = (j == v.k1b) ? ~v.r1 : v.r1;
        dec1_data_in   = (j == v.k1b) ? ~v.d1 : v.d1;
        dec2_done_in   = (j == v.k2);
        dec2_result_in = v.r2;
        dec2_data_in   = v.d2;
      end
    end
    chk({nm, ".rsp_seen"}, 80'(seen), 80'(1));
    chk({nm, ".latency"}, 80'(lat), 80'(v.lat));
    chk({nm, ".result"}, 80'(rsp_result_out), 80'(v.er));
    chk({nm, ".data"}, 80'(rsp_data_out), 80'(v.ed));
    chk({nm, ".path"}, 80'(rsp_path_out), 80'(v.ep));
    chk({nm, ".timeout"}, 80'(rsp_timeout_out), 80'(v.et));
    clr_cnt_in = clr_hs;
    step();
    clr_cnt_in = 1'b0;
    chk({nm, ".post_valid"}, 80'(rsp_valid_out), 80'(0));
    chk({nm, ".post_ready"}, 80'(req_ready_out), 80'(1));
  endtask

  initial begin
    logic [DATA_W-1:0] held_data;
    logic [CW_W-1:0]   cw_b;
    bit                done_ok;

    vecs[0] = '{cw:80'h1, r1:0, d1:D1, k1:0,  k1b:-1, r2:0, d2:D2, k2:0,  er:0, ed:D2, ep:1, et:0, lat:3};
    vecs[1] = '{cw:80'h2, r1:0, d1:A5, k1:0,  k1b:-1, r2:1, d2:D2, k2:3,  er:0, ed:A5, ep:0, et:0, lat:6};
    vecs[2] = '{cw:80'h3, r1:1, d1:D1, k1:0,  k1b:-1, r2:0, d2:D2, k2:1,  er:0, ed:D2, ep:1, et:0, lat:4};
    vecs[3] = '{cw:80'h4, r1:1, d1:D1, k1:2,  k1b:-1, r2:1, d2:D2, k2:2,  er:1, ed:D2, ep:1, et:0, lat:5};
    vecs[4] = '{cw:80'h5, r1:0, d1:D1, k1:-1, k1b:-1, r2:1, d2:0,  k2:0,  er:1, ed:0,  ep:1, et:1, lat:18};
    vecs[5] = '{cw:80'h6, r1:0, d1:D1, k1:5,  k1b:-1, r2:0, d2:D2, k2:-1, er:0, ed:D1, ep:0, et:1, lat:18};
    vecs[6] = '{cw:80'h7, r1:0, d1:D1, k1:-1, k1b:-1, r2:0, d2:D2, k2:-1, er:1, ed:0,  ep:1, et:1, lat:18};
    vecs[7] = '{cw:80'h8, r1:0, d1:D1, k1:15, k1b:-1, r2:0, d2:D2, k2:-1, er:0, ed:D1, ep:0, et:1, lat:18};
    vecs[8] = '{cw:80'h9, r1:0, d1:D1, k1:1,  k1b:2,  r2:1, d2:D2, k2:4,  er:0, ed:D1, ep:0, et:0, lat:7};
    vecs[9] = '{cw:80'hA, r1:0, d1:D1, k1:0,  k1b:-1, r2:0, d2:D2, k2:15, er:0, ed:D2, ep:1, et:0, lat:18};

    rst_n = 1'b0;
    req_valid_in = 1'b0; req_cw_in = '0; rsp_ready_in = 1'b0; clr_cnt_in = 1'b0;
    dec1_done_in = 1'b0; dec1_result_in = 1'b0; dec1_data_in = '0;
    dec2_done_in = 1'b0; dec2_result_in = 1'b0; dec2_data_in = '0;
    step();
    step();
    chk("reset.req_ready", 80'(req_ready_out), 80'(1));
    chk("reset.rsp_valid", 80'(rsp_valid_out), 80'(0));
    chk("reset.start", 80'({dec1_start_out, dec2_start_out}), 80'(0));
    chk("reset.dec_cw", 80'(dec_cw_out), 80'(0));
    chk("reset.rsp_fields", 80'({rsp_result_out, rsp_path_out, rsp_timeout_out, rsp_data_out}), 80'(0));
    chk_cnt("reset", 0, 0, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i), 1'b0);

    pulse_clr();
    do_txn(vecs[0], "agree_ok", 1'b0);
    chk_cnt("agree_ok", 0, 0, 0);

    pulse_clr();
    do_txn(vecs[1], "disagree", 1'b0);
    chk_cnt("disagree", 0, 1, 0);

    pulse_clr();
    do_txn(vecs[4], "timeout", 1'b0);
    chk_cnt("timeout", 1, 0, 1);
    dec1_done_in = 1'b1; dec1_result_in = 1'b0; dec1_data_in = D1;
    step();
    dec1_done_in = 1'b0;
    chk("late_done.rsp_valid", 80'(rsp_valid_out), 80'(0));
    chk("late_done.req_ready", 80'(req_ready_out), 80'(1));
    chk("late_done.start", 80'({dec1_start_out, dec2_start_out}), 80'(0));
    chk_cnt("late_done", 1, 0, 1);

    // Reset in the middle of WAIT: everything returns to reset values, no response.
    req_valid_in = 1'b1; req_cw_in = 80'hBEEF;
    step();
    req_valid_in = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", 80'(req_ready_out), 80'(1));
    chk("midrst.rsp_valid", 80'(rsp_valid_out), 80'(0));
    chk("midrst.dec_cw", 80'(dec_cw_out), 80'(0));
    chk("midrst.rsp_data", 80'(rsp_data_out), 80'(0));
    chk_cnt("midrst", 0, 0, 0);
    step();
    rst_n = 1'b1;
    dec1_done_in = 1'b1; dec2_done_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      dec1_done_in = 1'b0; dec2_done_in = 1'b0;
      chk("midrst.no_rsp", 80'(rsp_valid_out), 80'(0));
    end
    do_txn(vecs[2], "after_rst", 1'b0);

    // Backpressure on the response with a new request already pending.
    cw_b = 80'hC0DE_0000_0000_0000_0042;
    rsp_ready_in = 1'b0;
    req_valid_in = 1'b1; req_cw_in = 80'hAAAA;
    step();
    req_valid_in = 1'b0;
    step();
    dec1_done_in = 1'b1; dec1_result_in = 1'b0; dec1_data_in = D1;
    dec2_done_in = 1'b1; dec2_result_in = 1'b0; dec2_data_in = D2;
    step();
    dec1_done_in = 1'b0; dec2_done_in = 1'b0;
    req_valid_in = 1'b1; req_cw_in = cw_b;
    held_data = D2;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", 80'(rsp_valid_out), 80'(1));
      chk("bp.rsp_data", 80'(rsp_data_out), 80'(held_data));
      chk("bp.rsp_res_path", 80'({rsp_result_out, rsp_path_out}), 80'(2'b01));
      chk("bp.req_ready", 80'(req_ready_out), 80'(0));
      step();
    end
    rsp_ready_in = 1'b1;
    chk("bp.rsp_valid_hs", 80'(rsp_valid_out), 80'(1));
    step();
    chk("bp.ready_after_hs", 80'(req_ready_out), 80'(1));
    step();
    req_valid_in = 1'b0;
    chk("bp.new_start", 80'(dec1_start_out), 80'(1));
    chk("bp.new_cw", 80'(dec_cw_out), cw_b);
    step();
    dec1_done_in = 1'b1; dec2_done_in = 1'b1;
    done_ok = 1'b0;
    for (int i = 0; i < 5 && !done_ok; i++) begin
      step();
      dec1_done_in = 1'b0; dec2_done_in = 1'b0;
      done_ok = rsp_valid_out;
    end
    chk("bp.second_rsp", 80'(done_ok), 80'(1));
    step();

    // Saturation at 2^CNT_W-1, then clear on a handshake cycle.
    pulse_clr();
    for (int i = 0; i < 5; i++) do_txn(vecs[3], $sformatf("sat%0d", i), 1'b0);
    chk_cnt("sat", 3, 0, 0);
    do_txn(vecs[3], "clr_on_hs", 1'b1);
    chk_cnt("clr_on_hs", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
